regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Writer side of the register file: MEM/WB pipeline register plus write-port arbiter.
//  Registers the MEM-stage result and selects the ALU or load value.
//  Merges these writes with results from a long-latency unit (mult/div) that are
//  buffered in a small FIFO.
//  Drives the single register-file write port (WE3/A3/WD3); the file samples on negedge clk.
// PARAMETERS
//  Data_Width   32  datapath width
//  addres_width 5   register address width (2**addres_width registers)
//  LU_DEPTH     2   long-latency result FIFO depth (power of 2, >=2)
// PORTS
//  clk        in   1             clock; all state updates on posedge
//  rst        in   1             asynchronous active-low reset
//  RegWriteM  in   1             MEM-stage register write enable
//  MemtoRegM  in   1             1: write ReadDataM, 0: write ALUOutM
//  WriteRegM  in   addres_width  MEM-stage destination register
//  ALUOutM    in   Data_Width    MEM-stage ALU result
//  ReadDataM  in   Data_Width    MEM-stage load data
//  lu_valid   in   1             long-latency result offered
//  lu_ready   out  1             FIFO can accept (= !full, registered state only)
//  lu_rd      in   addres_width  long-latency destination register
//  lu_data    in   Data_Width    long-latency result
//  WE3        out  1             register-file write enable
//  A3         out  addres_width  register-file write address
//  WD3        out  Data_Width    register-file write data
// BEHAVIOUR
//  - Reset (async, rst=0): MEM/WB regs cleared, FIFO empty.
//    WE3=0, A3=0, WD3=0, lu_ready=1.
//  - The MEM/WB register captures RegWriteM/MemtoRegM/WriteRegM/ALUOutM/ReadDataM on
//    every posedge. There is no stall or flush input.
//  - ResultW = MemtoRegW ? ReadDataW : ALUOutW.
//  - pipe_wr = RegWriteW && WriteRegW!=0.
//  - WE3/A3/WD3 are combinational from registered state only, stable before the negedge.
//  - Priority: if pipe_wr, the pipeline owns the port (WE3=1, A3=WriteRegW, WD3=ResultW).
//    Otherwise, if the FIFO is non-empty, the head is popped that cycle:
//    WE3=(head_rd!=0), A3=head_rd, WD3=head_data.
//    Otherwise WE3=0, A3=0, WD3=0.
//  - Register 0: a pipeline write to r0 is dropped and leaves the slot free for the FIFO.
//    A FIFO entry for r0 is popped with WE3=0.
//  - FIFO push on lu_valid && lu_ready; the entry is eligible for write one cycle later at
//    the earliest. Latency: push at edge N -> WE3 in cycle N+1 if the pipeline is idle.
//  - Full: lu_ready=0. A pop in the same cycle does not raise ready until the next cycle;
//    there is no combinational ready path.
//  - Push and pop in the same cycle are both performed. Pointers wrap modulo LU_DEPTH and
//    are sized log2(LU_DEPTH)+1.
//  - The FIFO has no starvation bound; the head waits while the pipeline writes every cycle.
//  - Write-after-write ordering between the pipeline and the FIFO is not enforced here
//    (see RF_SCOREBOARD_EN).
//  - Reset mid-operation discards FIFO contents and the MEM/WB register; no write is issued
//    for discarded entries.
// CONFIGURATION
//  RF_SCOREBOARD_EN defined:
//  - Adds ports: issue_valid in 1, issue_rd in addres_width,
//    pending out 2**addres_width.
//  - pending[r] is set at the posedge when issue_valid && issue_rd==r && r!=0.
//  - pending[r] is cleared at the posedge after the FIFO head for r is written (popped).
//  - Set and clear of the same r in one cycle: set wins.
//  - pending[0] is always 0. Reset clears all bits.
//  RF_SCOREBOARD_EN undefined: these ports and the logic are absent; behaviour is otherwise
//  identical.
// STRUCTURE
//  - Shared package mips_pkg: DATA_WIDTH, REG_ADDR_W, NUM_REGS, REG_ZERO=0, LU_DEPTH default.
//  - One sub-module, wb_result_fifo: a synchronous FIFO with push/pop/full/empty/head and an
//    async active-low reset.
//  - The top level holds the MEM/WB register, the priority mux and the optional scoreboard.
// TESTING
//  1. rst=0 mid-run with 2 FIFO entries -> WE3=0 immediately; lu_ready=1; after release no
//     writes from the old entries.
//  2. RegWriteM=1, WriteRegM=5, MemtoRegM=1, ReadDataM=32'hDEADBEEF -> next cycle WE3=1,
//     A3=5, WD3=32'hDEADBEEF.
//  3. Pipeline writes r3 every cycle for 4 cycles while lu pushes (r7, 32'h11) -> lu entry
//     held. It is written (A3=7, WD3=32'h11) in the first cycle with RegWriteW=0.
//  4. Pipeline writes r0 while the FIFO holds (r9, 32'h22) -> same cycle WE3=1, A3=9,
//     WD3=32'h22.
//  5. Push 3 results back-to-back with pipeline busy -> lu_ready=0 after 2 accepts; third
//     held by the source. After the pipeline goes idle, writes occur in push order.
//  6. (RF_SCOREBOARD_EN) issue r12 -> pending[12]=1. Issue r12 again in the same cycle its
//     FIFO result is written -> pending[12] stays 1. issue r0 -> pending unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared datapath constants for the MIPS core, plus the write-port source
// selector used by the register-file write arbiter.
package mips_pkg;

   localparam int DATA_WIDTH       = 32;
   localparam int REG_ADDR_W       = 5;
   localparam int NUM_REGS         = 1 << REG_ADDR_W;
   localparam int REG_ZERO         = 0;
   localparam int LU_DEPTH_DEFAULT = 2;

   // Who owns the single register-file write port in the current cycle.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PIPE = 2'd1,
      SRC_FIFO = 2'd2
   } wb_src_e;

endpackage : mips_pkg

// File: rtl/regfile_write_arbiter_if.sv
// Bus between the MEM stage / long-latency unit and the register-file writer.
// Scoreboard signals exist only when RF_SCOREBOARD_EN is defined.
interface regfile_write_arbiter_if #(
   parameter int Data_Width   = 32,
   parameter int addres_width = 5
);

   logic                    RegWriteM;
   logic                    MemtoRegM;
   logic [addres_width-1:0] WriteRegM;
   logic [Data_Width-1:0]   ALUOutM;
   logic [Data_Width-1:0]   ReadDataM;

   logic                    lu_valid;
   logic                    lu_ready;
   logic [addres_width-1:0] lu_rd;
   logic [Data_Width-1:0]   lu_data;

   logic                    WE3;
   logic [addres_width-1:0] A3;
   logic [Data_Width-1:0]   WD3;

`ifdef RF_SCOREBOARD_EN
   logic                         issue_valid;
   logic [addres_width-1:0]      issue_rd;
   logic [(2**addres_width)-1:0] pending;

   modport master (
      output RegWriteM, MemtoRegM, WriteRegM, ALUOutM, ReadDataM,
      output lu_valid, lu_rd, lu_data, issue_valid, issue_rd,
      input  lu_ready, WE3, A3, WD3, pending
   );

   modport slave (
      input  RegWriteM, MemtoRegM, WriteRegM, ALUOutM, ReadDataM,
      input  lu_valid, lu_rd, lu_data, issue_valid, issue_rd,
      output lu_ready, WE3, A3, WD3, pending
   );
`else
   modport master (
      output RegWriteM, MemtoRegM, WriteRegM, ALUOutM, ReadDataM,
      output lu_valid, lu_rd, lu_data,
      input  lu_ready, WE3, A3, WD3
   );

   modport slave (
      input  RegWriteM, MemtoRegM, WriteRegM, ALUOutM, ReadDataM,
      input  lu_valid, lu_rd, lu_data,
      output lu_ready, WE3, A3, WD3
   );
`endif

endinterface : regfile_write_arbiter_if

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO buffering long-latency results until the write port
// is free. DEPTH must be a power of two; pointers carry one extra wrap bit.
module wb_result_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which
   // entries are valid, and leaving the array out of reset keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_data;
   end

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                    (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
   assign o_head  = r_mem[r_rd_ptr[IDX_W-1:0]];

endmodule : wb_result_fifo

// File: rtl/regfile_write_arbiter.sv
// MEM/WB pipeline register plus write-port arbiter merging pipeline results with
// buffered long-latency results. Optional pending scoreboard: RF_SCOREBOARD_EN.
module regfile_write_arbiter
   import mips_pkg::*;
#(
   parameter int Data_Width   = DATA_WIDTH,
   parameter int addres_width = REG_ADDR_W,
   parameter int LU_DEPTH     = LU_DEPTH_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   regfile_write_arbiter_if.slave   wb
);

   localparam int ENTRY_W = addres_width + Data_Width;

   logic                    r_reg_write_w;
   logic                    r_mem_to_reg_w;
   logic [addres_width-1:0] r_write_reg_w;
   logic [Data_Width-1:0]   r_alu_out_w;
   logic [Data_Width-1:0]   r_read_data_w;

   logic [Data_Width-1:0]   w_result_w;
   logic                    w_pipe_wr;
   logic                    w_fifo_full;
   logic                    w_fifo_empty;
   logic                    w_fifo_pop;
   logic [ENTRY_W-1:0]      w_fifo_head;
   logic [addres_width-1:0] w_head_rd;
   logic [Data_Width-1:0]   w_head_data;
   wb_src_e                 w_src;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_reg_write_w  <= 1'b0;
         r_mem_to_reg_w <= 1'b0;
         r_write_reg_w  <= '0;
         r_alu_out_w    <= '0;
         r_read_data_w  <= '0;
      end else begin
         r_reg_write_w  <= wb.RegWriteM;
         r_mem_to_reg_w <= wb.MemtoRegM;
         r_write_reg_w  <= wb.WriteRegM;
         r_alu_out_w    <= wb.ALUOutM;
         r_read_data_w  <= wb.ReadDataM;
      end
   end

   assign w_result_w = r_mem_to_reg_w ? r_read_data_w : r_alu_out_w;

   // A pipeline write to r0 is a no-op and must not block the FIFO head.
   assign w_pipe_wr = r_reg_write_w && (r_write_reg_w != addres_width'(REG_ZERO));

   wb_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (LU_DEPTH)
   ) u_lu_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (wb.lu_valid),
      .i_push_data ({wb.lu_rd, wb.lu_data}),
      .i_pop       (w_fifo_pop),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_head      (w_fifo_head)
   );

   assign w_head_rd   = w_fifo_head[ENTRY_W-1:Data_Width];
   assign w_head_data = w_fifo_head[Data_Width-1:0];
   assign w_fifo_pop  = (w_src == SRC_FIFO);

   // Ready comes from registered FIFO state only, so a same-cycle pop never
   // opens a combinational path from the pipeline to the long-latency source.
   assign wb.lu_ready = !w_fifo_full;

   always_comb begin
      if (w_pipe_wr)          w_src = SRC_PIPE;
      else if (!w_fifo_empty) w_src = SRC_FIFO;
      else                    w_src = SRC_NONE;
   end

   // NOTE: every output gets a default before the case so no path leaves a
   // value held, which would otherwise infer a latch.
   always_comb begin
      wb.WE3 = 1'b0;
      wb.A3  = '0;
      wb.WD3 = '0;
      case (w_src)
         SRC_PIPE: begin
            wb.WE3 = 1'b1;
            wb.A3  = r_write_reg_w;
            wb.WD3 = w_result_w;
         end
         SRC_FIFO: begin
            wb.WE3 = (w_head_rd != addres_width'(REG_ZERO));
            wb.A3  = w_head_rd;
            wb.WD3 = w_head_data;
         end
         default: ;
      endcase
   end

`ifdef RF_SCOREBOARD_EN
   localparam int NUM_R = 2 ** addres_width;

   logic [NUM_R-1:0] r_pending;
   logic [NUM_R-1:0] w_pending_nxt;

   // Clear is applied before set so a re-issue in the retiring cycle wins.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_fifo_pop) w_pending_nxt[w_head_rd] = 1'b0;
      if (wb.issue_valid) w_pending_nxt[wb.issue_rd] = 1'b1;
      w_pending_nxt[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_pending <= '0;
      else      r_pending <= w_pending_nxt;
   end

   assign wb.pending = r_pending;
`endif

endmodule : regfile_write_arbiter

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the write-port rules.
module tb_regfile_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int D  = 2;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } lu_ent_t;

   logic clk;
   logic rst;
   int   err_cnt = 0;
   int   chk_cnt = 0;

   regfile_write_arbiter_if #(.Data_Width(DW), .addres_width(AW)) bus ();

   regfile_write_arbiter #(
      .Data_Width   (DW),
      .addres_width (AW),
      .LU_DEPTH     (D)
   ) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: what the MEM/WB register holds and what the FIFO holds.
   logic          m_rw;
   logic          m_mtr;
   logic [AW-1:0] m_wr;
   logic [DW-1:0] m_alu;
   logic [DW-1:0] m_rdd;
   lu_ent_t       m_q[$];
   logic [31:0]   m_pending;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_rw = 0; m_mtr = 0; m_wr = '0; m_alu = '0; m_rdd = '0;
      m_q.delete();
      m_pending = '0;
   endtask

   // Called at posedge+1: drive inputs, check outputs, advance one cycle, update model.
   task automatic step(input logic rw, input logic mtr, input logic [AW-1:0] wr,
                       input logic [DW-1:0] alu, input logic [DW-1:0] rdd,
                       input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                       input logic iv, input logic [AW-1:0] ird, output logic acc);
      logic          pipe;
      logic          pop;
      logic          e_we;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_d;
      logic          e_rdy;
      lu_ent_t       ent;
      bus.RegWriteM = rw;  bus.MemtoRegM = mtr; bus.WriteRegM = wr;
      bus.ALUOutM   = alu; bus.ReadDataM = rdd;
      bus.lu_valid  = lv;  bus.lu_rd     = lrd; bus.lu_data   = ld;
`ifdef RF_SCOREBOARD_EN
      bus.issue_valid = iv; bus.issue_rd = ird;
`endif
      #1;
      pipe  = m_rw && (m_wr != 0);
      pop   = !pipe && (m_q.size() > 0);
      e_rdy = (m_q.size() < D);
      if (pipe) begin
         e_we = 1; e_a = m_wr; e_d = m_mtr ? m_rdd : m_alu;
      end else if (pop) begin
         e_we = (m_q[0].rd != 0); e_a = m_q[0].rd; e_d = m_q[0].data;
      end else begin
         e_we = 0; e_a = '0; e_d = '0;
      end
      check("we3", 64'(bus.WE3), 64'(e_we));
      check("a3", 64'(bus.A3), 64'(e_a));
      check("wd3", 64'(bus.WD3), 64'(e_d));
      check("lu_ready", 64'(bus.lu_ready), 64'(e_rdy));
`ifdef RF_SCOREBOARD_EN
      check("pending", 64'(bus.pending), 64'(m_pending));
`endif
      @(posedge clk);
      #1;
      if (pop) begin
`ifdef RF_SCOREBOARD_EN
         m_pending[m_q[0].rd] = 1'b0;
`endif
         void'(m_q.pop_front());
      end
      acc = lv && e_rdy;
      if (acc) begin
         ent.rd = lrd; ent.data = ld;
         m_q.push_back(ent);
      end
`ifdef RF_SCOREBOARD_EN
      if (iv) m_pending[ird] = 1'b1;
      m_pending[0] = 1'b0;
`endif
      m_rw = rw; m_mtr = mtr; m_wr = wr; m_alu = alu; m_rdd = rdd;
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, '0, '0, 0, '0, acc);
   endtask

   initial begin
      logic          acc;
      logic [AW-1:0] q5_rd [3];
      logic [DW-1:0] q5_d  [3];
      int            k;

      rst = 1'b0;
      bus.RegWriteM = 0; bus.MemtoRegM = 0; bus.WriteRegM = '0;
      bus.ALUOutM = '0; bus.ReadDataM = '0;
      bus.lu_valid = 0; bus.lu_rd = '0; bus.lu_data = '0;
`ifdef RF_SCOREBOARD_EN
      bus.issue_valid = 0; bus.issue_rd = '0;
`endif
      model_clear();
      #3;
      check("rst_we3", 64'(bus.WE3), 64'(0));
      check("rst_a3", 64'(bus.A3), 64'(0));
      check("rst_wd3", 64'(bus.WD3), 64'(0));
      check("rst_ready", 64'(bus.lu_ready), 64'(1));
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Load data selected through MemtoReg.
      step(1, 1, 5'd5, 32'h1234, 32'hDEADBEEF, 0, '0, '0, 0, '0, acc);
      step(1, 0, 5'd6, 32'hA5A5, 32'h5A5A, 0, '0, '0, 0, '0, acc);
      idle(2);

      // FIFO entry held while the pipeline owns the port.
      step(1, 0, 5'd3, 32'h33, '0, 1, 5'd7, 32'h11, 0, '0, acc);
      for (int i = 0; i < 3; i++) step(1, 0, 5'd3, 32'h33 + i, '0, 0, '0, '0, 0, '0, acc);
      idle(3);

      // Pipeline write to r0 frees the slot for the FIFO head.
      step(1, 0, 5'd4, 32'h44, '0, 1, 5'd9, 32'h22, 0, '0, acc);
      step(1, 0, 5'd0, 32'h99, '0, 0, '0, '0, 0, '0, acc);
      idle(2);

      // Three back-to-back results with the pipeline busy; source holds until accepted.
      q5_rd[0] = 5'd10; q5_rd[1] = 5'd11; q5_rd[2] = 5'd12;
      q5_d[0]  = 32'hA0; q5_d[1] = 32'hA1; q5_d[2] = 32'hA2;
      k = 0;
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 5'd3, 32'h50 + i, '0, (k < 3), (k < 3) ? q5_rd[k] : '0,
              (k < 3) ? q5_d[k] : '0, 0, '0, acc);
         if (acc) k++;
      end
      check("held_count", 64'(k), 64'(2));
      while (k < 3) begin
         step(0, 0, '0, '0, '0, 1, q5_rd[k], q5_d[k], 0, '0, acc);
         if (acc) k++;
      end
      idle(4);

      // FIFO entry for r0 is popped silently.
      step(0, 0, '0, '0, '0, 1, 5'd0, 32'h77, 0, '0, acc);
      idle(2);

`ifdef RF_SCOREBOARD_EN
      step(0, 0, '0, '0, '0, 1, 5'd12, 32'hC0, 1, 5'd12, acc);
      step(0, 0, '0, '0, '0, 0, '0, '0, 1, 5'd12, acc);
      step(0, 0, '0, '0, '0, 0, '0, '0, 1, 5'd0, acc);
      idle(2);
`endif

      // Reset mid-run with two entries queued and the pipeline writing.
      for (int i = 0; i < 3; i++)
         step(1, 0, 5'd8, 32'h80 + i, '0, 1, 5'(20 + i), 32'hE0 + i, 1, 5'(20 + i), acc);
      rst = 1'b0;
      #1;
      check("mid_rst_we3", 64'(bus.WE3), 64'(0));
      check("mid_rst_ready", 64'(bus.lu_ready), 64'(1));
`ifdef RF_SCOREBOARD_EN
      check("mid_rst_pending", 64'(bus.pending), 64'(0));
`endif
      bus.RegWriteM = 0; bus.lu_valid = 0;
`ifdef RF_SCOREBOARD_EN
      bus.issue_valid = 0;
`endif
      model_clear();
      #1;
      rst = 1'b1;
      idle(4);

      // Random traffic, biased so the FIFO both fills and drains.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 2) == 0), $urandom_range(0, 1), AW'($urandom_range(0, 31)),
              $urandom, $urandom,
              ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 31)), $urandom,
              ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 31)), acc);
      end
      idle(4);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule : tb_regfile_write_arbiter
